// File: rtl/serial_add_full_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the iteration counter width helper.
package serial_add_full_pkg;

  // 2'b11 is unused; the FSM recovers from it to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADD  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Bit counter width for a given operand width: clog2(w)+1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_add_full_fa_cell.sv
// One-bit full adder built from two half-adder stages and an OR.
// Ports:
//   a, b, cin : operand bits and carry-in
//   sum_c     : a ^ b ^ cin
//   carry_c   : a&b | cin&(a^b)
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum_c,
  output logic carry_c
);

  logic ha0_sum;
  logic ha0_carry;
  logic ha1_carry;

  // First half adder: a + b.
  assign ha0_sum   = a ^ b;
  assign ha0_carry = a & b;

  // Second half adder: partial sum + cin.
  assign sum_c     = ha0_sum ^ cin;
  assign ha1_carry = ha0_sum & cin;

  assign carry_c   = ha0_carry | ha1_carry;

endmodule

// File: rtl/serial_add_full.sv
// Bit-serial WIDTH-bit adder: captures two operands and a carry-in on an
// accepted start, adds LSB first one bit per clock through a single full
// adder cell, then strobes done for one cycle with the parallel result.
// Ports:
//   clk     : rising-edge clock
//   reset   : synchronous active-low reset
//   start   : begin an addition (accepted only while ready=1)
//   a_in    : operand A, captured on accept
//   b_in    : operand B, captured on accept
//   c_in    : carry-in, captured on accept
//   ready   : high only in IDLE
//   sum_out : result register, valid with done=1, held until next accept
//   c_out   : final carry, valid with done=1, held until next accept
//   done    : one-cycle result strobe
module serial_add_full
  import serial_add_full_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out,
  output logic             done
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;

  logic               cell_sum;
  logic               cell_carry;

  // The single adder cell consumes the operand LSBs and the carry flop.
  fa_cell u_fa_cell (
    .a       (a_q[0]),
    .b       (b_q[0]),
    .cin     (carry_q),
    .sum_c   (cell_sum),
    .carry_c (cell_carry)
  );

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      count_q <= count_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    count_d = count_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = c_in;
          sum_d   = '0;
          count_d = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        // New sum bit enters at the MSB; after WIDTH shifts bit 0 is the LSB.
        sum_d   = WIDTH'({cell_sum, sum_q} >> 1);
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = cell_carry;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Decoding the next state keeps ready/done aligned with state_q.
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  assign ready   = ready_q;
  assign done    = done_q;
  assign sum_out = sum_q;
  assign c_out   = carry_q;

endmodule

// File: doc/serial_add_full.md
Name: serial_add_full

Overview:
- Bit-serial N-bit adder built around a single one-bit full-adder cell, plus operand shift registers, a carry flip-flop and a result shift register.
- Accepts two parallel operands and a carry-in on a start handshake.
- Adds LSB first, one bit per clock.
- Presents the parallel sum and carry-out with a one-cycle done strobe.
- Sits upstream of result consumers and downstream of operand sources; trades area for WIDTH-cycle latency.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 1..32)

Ports:
clk  input  1  rising-edge clock, the only clock
reset  input  1  synchronous, active-low reset
start  input  1  request to begin an addition; sampled only while ready=1
a_in  input  WIDTH  operand A, captured on accepted start
b_in  input  WIDTH  operand B, captured on accepted start
c_in  input  1  carry-in, captured on accepted start
ready  output  1  high only in IDLE; start is accepted at the edge where start=1 and ready=1
sum_out  output  WIDTH  result register; valid when done=1, held until next accept
c_out  output  1  final carry; valid when done=1, held until next accept
done  output  1  one-cycle strobe marking valid result

Behaviour:
- Reset: clk edge with reset=0 forces state=IDLE. Clears ready=1, done=0, sum_out=0, c_out=0, carry FF=0, count=0, operand regs=0. Applies from any state; an in-flight addition is discarded and produces no done.
- FSM states: IDLE, ADD, DONE.
- IDLE, on accept (start=1):
  - load A_reg<=a_in, B_reg<=b_in, carry<=c_in
  - sum_reg<=0, count<=0
  - next state ADD
  - otherwise remain in IDLE; all registers hold.
- ADD, each edge:
  - cell inputs are A_reg[0], B_reg[0], carry
  - sum_reg<={cell_sum, sum_reg[WIDTH-1:1]}
  - A_reg and B_reg shift right with 0 fill
  - carry<=cell_carry, count<=count+1
  - when count==WIDTH-1 at the edge, next state is DONE. WIDTH=1 therefore spends exactly one cycle in ADD.
- DONE: done=1 for exactly one cycle; sum_out=sum_reg, c_out=carry. Next edge goes to IDLE unconditionally.
- Latency: accept at edge k; done is high in the cycle following edge k+WIDTH. Accept-to-accept minimum is WIDTH+2 edges.
- start is ignored in ADD and DONE; it is not queued. A start held high through DONE is accepted at the first IDLE edge.
- a_in, b_in and c_in are don't-care except at the accept edge.
- Arithmetic: {c_out, sum_out} = a_in + b_in + c_in, modulo 2^(WIDTH+1). Unsigned; no overflow flag.
- sum_out shows partial shifts during ADD; consumers use it only with done=1 or in IDLE.
- count width is clog2(WIDTH)+1. The counter never wraps because it is cleared on accept.
- ready is a registered decode of state==IDLE. done is a registered decode of state==DONE. No combinational path from start to ready or done.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'b00, ADD=2'b01, DONE=2'b10; 2'b11 is illegal and recovers to IDLE
  - the count-width function/constant.
- One sub-module: fa_cell.
  - Purely combinational one-bit full adder: sum=a^b^cin, carry=ab|cin(a^b).
  - Built from two half-adder stages and an OR.
  - Instantiated once; no delays on the synthesis path.
- All other logic lives in serial_add_full.

Test Plan:
- WIDTH=8, after reset: start with a_in=0x5A, b_in=0x3C, c_in=0 -> done high 9 cycles after accept; sum_out=0x96, c_out=0; ready low throughout ADD and DONE.
- Carry ripple: a_in=0xFF, b_in=0x01, c_in=0 -> sum_out=0x00, c_out=1. Then a_in=0xFF, b_in=0xFF, c_in=1 -> sum_out=0xFF, c_out=1.
- start pulsed mid-ADD with different operands -> ignored; first result unchanged. Start held high across DONE -> second accept on the IDLE edge; two done pulses separated by exactly 10 edges.
- reset=0 asserted at ADD cycle 4 -> next edge: ready=1, done=0, sum_out=0, c_out=0; no done pulse ever appears for the aborted operation.
- WIDTH=1 build: a=1, b=1, c_in=1 -> done 2 cycles after accept; sum_out=1, c_out=1.
- Random check: 200 randomized WIDTH=8 operand/carry sets, compared against the reference sum -> zero mismatches; done pulse always exactly one cycle wide.
